// File: rtl/mdu_if.sv
// ============================================================================
//  Module      : mdu_if
//  Description : Request / write-back handshake bundle for the iterative MDU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdu_if #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
);
  logic                 mdu_i_valid;
  logic                 mdu_o_ready;
  logic [2:0]           mdu_i_op;
  logic [WIDTH-1:0]     mdu_i_valA;
  logic [WIDTH-1:0]     mdu_i_valB;
  logic [REG_WIDTH-1:0] mdu_i_rd;
  logic                 mdu_i_flush;
  logic                 mdu_o_valid;
  logic                 mdu_i_wb_ready;
  logic [WIDTH-1:0]     mdu_o_result;
  logic [REG_WIDTH-1:0] mdu_o_rd;
  logic                 mdu_o_busy;

  // Upstream core / write-back side
  modport master (
    output mdu_i_valid, mdu_i_op, mdu_i_valA, mdu_i_valB, mdu_i_rd,
           mdu_i_flush, mdu_i_wb_ready,
    input  mdu_o_ready, mdu_o_valid, mdu_o_result, mdu_o_rd, mdu_o_busy
  );

  // The MDU itself
  modport slave (
    input  mdu_i_valid, mdu_i_op, mdu_i_valA, mdu_i_valB, mdu_i_rd,
           mdu_i_flush, mdu_i_wb_ready,
    output mdu_o_ready, mdu_o_valid, mdu_o_result, mdu_o_rd, mdu_o_busy
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative RV32M multiply/divide unit (shift-add multiply,
//                restoring divide, one bit per cycle). Optional feature macro:
//                MDU_EARLY_OUT_EN (zero-operand / divide-by-zero early out).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  wire   clk,
  input  wire   rst,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [2:0]             op;
  logic                   neg;
  logic                   div_zero;
  logic [WIDTH-1:0]       mag_b;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH:0]         rem;
  logic [CW-1:0]          count;
  logic                   valid_q;
  logic [WIDTH-1:0]       result_q;
  logic [REG_WIDTH-1:0]   rd_q;

  assign bus.mdu_o_ready  = (state == IDLE);
  assign bus.mdu_o_busy   = (state != IDLE);
  assign bus.mdu_o_valid  = valid_q;
  assign bus.mdu_o_result = result_q;
  assign bus.mdu_o_rd     = rd_q;

  logic accept;
  assign accept = bus.mdu_i_valid && (state == IDLE);

  // Operand conditioning at accept time
  logic             a_signed, b_signed, sign_a, sign_b, in_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  always_comb begin
    a_signed = (bus.mdu_i_op == 3'd1) || (bus.mdu_i_op == 3'd2) ||
               (bus.mdu_i_op == 3'd4) || (bus.mdu_i_op == 3'd6);
    b_signed = (bus.mdu_i_op == 3'd1) || (bus.mdu_i_op == 3'd4) ||
               (bus.mdu_i_op == 3'd6);
    sign_a   = a_signed && bus.mdu_i_valA[WIDTH-1];
    sign_b   = b_signed && bus.mdu_i_valB[WIDTH-1];
    mag_a_in = sign_a ? -bus.mdu_i_valA : bus.mdu_i_valA;
    mag_b_in = sign_b ? -bus.mdu_i_valB : bus.mdu_i_valB;
    // REM takes the dividend's sign; everything else the XOR of both
    in_neg   = (bus.mdu_i_op == 3'd6) ? sign_a : (sign_a ^ sign_b);
  end

`ifdef MDU_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_res;
  always_comb begin
    if (bus.mdu_i_op[2]) begin
      early     = (bus.mdu_i_valB == '0);
      early_res = bus.mdu_i_op[1] ? bus.mdu_i_valA : '1;
    end else begin
      early     = (bus.mdu_i_valA == '0) || (bus.mdu_i_valB == '0);
      early_res = '0;
    end
  end
`endif

  // One iteration step for each datapath; acc holds {hi, multiplier} or the
  // dividend/quotient shift register in its low half.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     shifted, diff, rem_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remv, final_res;
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    shifted = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff    = shifted - {1'b0, mag_b};
    rem_nxt = diff[WIDTH] ? shifted : diff;
    q_nxt   = {acc[WIDTH-2:0], ~diff[WIDTH]};
    prod    = neg ? -mul_nxt : mul_nxt;
    quot    = (neg && !div_zero) ? -q_nxt : q_nxt;
    remv    = neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
    if (op[2])
      final_res = op[1] ? remv : quot;
    else if (op[1:0] == 2'd0)
      final_res = prod[WIDTH-1:0];
    else
      final_res = prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.mdu_i_flush) begin
      state    <= IDLE;
      op       <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op       <= bus.mdu_i_op;
            rd_q     <= bus.mdu_i_rd;
            neg      <= in_neg;
            div_zero <= (bus.mdu_i_valB == '0);
            mag_b    <= mag_b_in;
            acc      <= {{WIDTH{1'b0}}, mag_a_in};
            rem      <= '0;
            count    <= '0;
            state    <= CALC;
`ifdef MDU_EARLY_OUT_EN
            if (early) begin
              result_q <= early_res;
              valid_q  <= 1'b1;
              state    <= DONE;
            end
`endif
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (op[2]) begin
            acc <= {acc[2*WIDTH-1:WIDTH], q_nxt};
            rem <= rem_nxt;
          end else begin
            acc <= mul_nxt;
          end
          if (count == CW'(WIDTH - 1)) begin
            result_q <= final_res;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.mdu_i_wb_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
